// File: rtl/perf_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perf_event_counter: saturating pipeline event counters, halt freeze,    |
// | and a registered read port.                            Rev 1.0           |
// +--------------------------------------------------------------------------+
module perf_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             halt,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             frozen
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [6];
    logic [CNT_W-1:0] cnt_d [6];
    logic [CNT_W-1:0] halt_cycle_q, halt_cycle_d;
    logic [5:0]       ovf_q, ovf_d;
    logic             frozen_q, frozen_d;
    logic             ihit_err_q, ihit_err_d;
    logic             dhit_err_q, dhit_err_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             w_active;
    logic [5:0]       w_inc;
    logic [CNT_W-1:0] w_status;
    logic [CNT_W-1:0] w_sel_val;

    assign w_active = en & ~frozen_q;
    assign w_inc    = {dcache_hit, dcache_req, icache_hit, icache_req,
                       halt | reg_write | mem_write, 1'b1};

    always_comb begin
        w_status      = '0;
        w_status[8:0] = {ovf_q, dhit_err_q, ihit_err_q, frozen_q};
    end

    always_comb begin
        case (rd_sel)
            3'd0:    w_sel_val = cnt_q[0];
            3'd1:    w_sel_val = cnt_q[1];
            3'd2:    w_sel_val = cnt_q[2];
            3'd3:    w_sel_val = cnt_q[3];
            3'd4:    w_sel_val = cnt_q[4];
            3'd5:    w_sel_val = cnt_q[5];
            3'd6:    w_sel_val = halt_cycle_q;
            default: w_sel_val = w_status;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        halt_cycle_d = halt_cycle_q;
        ovf_d        = ovf_q;
        frozen_d     = frozen_q;
        ihit_err_d   = ihit_err_q;
        dhit_err_d   = dhit_err_q;
        rd_valid_d   = rd_en;
        rd_data_d    = rd_en ? w_sel_val : rd_data_q;

        // Reads above sample pre-update state, so a clear never hides a same-cycle read.
        if (clr) begin
            for (int i = 0; i < 6; i++) begin
                cnt_d[i] = '0;
            end
            halt_cycle_d = '0;
            ovf_d        = '0;
            frozen_d     = 1'b0;
            ihit_err_d   = 1'b0;
            dhit_err_d   = 1'b0;
        end else if (w_active) begin
            for (int i = 0; i < 6; i++) begin
                if (w_inc[i]) begin
                    if (&cnt_q[i]) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + c_one;
                    end
                end
            end
            if (halt) begin
                halt_cycle_d = cnt_q[0];
                frozen_d     = 1'b1;
            end
            if (icache_hit && !icache_req) begin
                ihit_err_d = 1'b1;
            end
            if (dcache_hit && !dcache_req) begin
                dhit_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
            halt_cycle_q <= '0;
            ovf_q        <= '0;
            frozen_q     <= 1'b0;
            ihit_err_q   <= 1'b0;
            dhit_err_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            halt_cycle_q <= halt_cycle_d;
            ovf_q        <= ovf_d;
            frozen_q     <= frozen_d;
            ihit_err_q   <= ihit_err_d;
            dhit_err_q   <= dhit_err_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign frozen   = frozen_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_perf_event_counter: vector table, corner sequences and random traffic|
// | checked against a behavioural model.                   Rev 1.0           |
// +--------------------------------------------------------------------------+
module tb_perf_event_counter;

    localparam int          W    = 16;
    localparam int unsigned MAXV = (1 << W) - 1;

    typedef struct packed {
        logic en, rw, mw, hlt, ireq, ihit, dreq, dhit, clr, rd;
        logic [2:0] sel;
    } in_t;

    typedef struct {
        in_t         i;
        bit          ev;
        int unsigned ed;
        bit          ef;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en, reg_write, mem_write, halt, icache_req, icache_hit;
    logic         dcache_req, dcache_hit, clr, rd_en;
    logic [2:0]   rd_sel;
    logic [W-1:0] rd_data;
    logic         rd_valid, frozen;

    int total = 0;
    int bad   = 0;

    perf_event_counter #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .reg_write(reg_write),
        .mem_write(mem_write), .halt(halt), .icache_req(icache_req),
        .icache_hit(icache_hit), .dcache_req(dcache_req),
        .dcache_hit(dcache_hit), .clr(clr), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .frozen(frozen)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain event counts, flags and a read latch.
    int unsigned m_cnt [6];
    int unsigned m_halt, m_rd;
    bit          m_frz, m_ie, m_de, m_rv;
    bit [5:0]    m_ovf;

    function automatic int unsigned m_val(input logic [2:0] s);
        if (s < 3'd6) return m_cnt[s];
        if (s == 3'd6) return m_halt;
        return {23'b0, m_ovf, m_de, m_ie, m_frz};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        m_halt = 0; m_ovf = '0; m_frz = 0; m_ie = 0; m_de = 0;
    endtask

    task automatic m_reset();
        m_clear();
        m_rd = 0; m_rv = 0;
    endtask

    task automatic m_edge(input in_t v);
        bit ev [6];
        int unsigned pre;
        m_rv = v.rd;
        if (v.rd) m_rd = m_val(v.sel);
        if (v.clr) begin
            m_clear();
        end else if (v.en && !m_frz) begin
            pre = m_cnt[0];
            ev[0] = 1; ev[1] = v.hlt | v.rw | v.mw;
            ev[2] = v.ireq; ev[3] = v.ihit; ev[4] = v.dreq; ev[5] = v.dhit;
            for (int i = 0; i < 6; i++)
                if (ev[i]) begin
                    if (m_cnt[i] == MAXV) m_ovf[i] = 1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            if (v.hlt) begin m_halt = pre; m_frz = 1; end
            if (v.ihit && !v.ireq) m_ie = 1;
            if (v.dhit && !v.dreq) m_de = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input bit e, rw, mw, hl, ir, ih, dr, dh, cl, rd,
                               input bit [2:0] s);
        in_t r;
        r.en = e; r.rw = rw; r.mw = mw; r.hlt = hl; r.ireq = ir; r.ihit = ih;
        r.dreq = dr; r.dhit = dh; r.clr = cl; r.rd = rd; r.sel = s;
        return r;
    endfunction

    function automatic in_t rdv(input bit [2:0] s);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, s);
    endfunction

    task automatic apply(input in_t v);
        en = v.en; reg_write = v.rw; mem_write = v.mw; halt = v.hlt;
        icache_req = v.ireq; icache_hit = v.ihit; dcache_req = v.dreq;
        dcache_hit = v.dhit; clr = v.clr; rd_en = v.rd; rd_sel = v.sel;
    endtask

    task automatic step(input in_t v);
        apply(v);
        @(posedge clk);
        m_edge(v);
        #1;
        check("model_rd_valid", {31'b0, rd_valid}, {31'b0, m_rv});
        check("model_rd_data", {16'b0, rd_data}, m_rd);
        check("model_frozen", {31'b0, frozen}, {31'b0, m_frz});
    endtask

    vec_t tab[$];

    task automatic add(input in_t i, input bit ev, input int unsigned ed, input bit ef);
        vec_t t;
        t.i = i; t.ev = ev; t.ed = ed; t.ef = ef;
        tab.push_back(t);
    endtask

    initial begin
        in_t idle, v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Retirement: rw on 0..3, mw on 3..4 -> 5 insts over 10 cycles.
        for (int k = 0; k < 10; k++)
            add(mk(1, k < 4, k == 3 || k == 4, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        add(rdv(1), 1, 5, 0);
        add(rdv(0), 1, 10, 0);
        add(idle, 0, 10, 0);
        // I-cache: 8 reqs, 6 hits, then a stray hit.
        for (int k = 0; k < 8; k++)
            add(mk(1, 0, 0, 0, 1, k < 6, 0, 0, 0, 0, 0), 0, 10, 0);
        add(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 0, 10, 0);
        add(rdv(2), 1, 8, 0);
        add(rdv(3), 1, 7, 0);
        add(rdv(7), 1, 2, 0);
        add(rdv(0), 1, 19, 0);
        // Cycle index 19 then halt with reg_write on index 20.
        add(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0, 19, 0);
        add(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 19, 1);
        for (int k = 0; k < 5; k++)
            add(mk(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0), 0, 19, 1);
        add(rdv(0), 1, 21, 1);
        add(rdv(1), 1, 6, 1);
        add(rdv(6), 1, 20, 1);
        add(rdv(2), 1, 8, 1);
        add(rdv(4), 1, 1, 1);
        add(rdv(7), 1, 3, 1);
        // Clear, 12 active cycles, then clr+halt+read in one cycle.
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 3, 0);
        for (int k = 0; k < 12; k++)
            add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 3, 0);
        add(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0), 1, 12, 0);
        add(rdv(0), 1, 0, 0);
        add(rdv(1), 1, 0, 0);
        add(rdv(6), 1, 0, 0);
        add(rdv(7), 1, 0, 0);

        // Reset state.
        apply(idle);
        m_reset();
        #1;
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_rd_data", {16'b0, rd_data}, 32'd0);
        check("reset_frozen", {31'b0, frozen}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        foreach (tab[k]) begin
            step(tab[k].i);
            check($sformatf("vec%0d_valid", k), {31'b0, rd_valid}, {31'b0, tab[k].ev});
            check($sformatf("vec%0d_data", k), {16'b0, rd_data}, tab[k].ed);
            check($sformatf("vec%0d_frozen", k), {31'b0, frozen}, {31'b0, tab[k].ef});
        end

        // Saturation of the cycle counter.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (MAXV + 3) step(v);
        step(rdv(0));
        check("sat_sel0", {16'b0, rd_data}, 32'h0000_FFFF);
        step(rdv(7));
        check("sat_status_bit3", {31'b0, rd_data[3]}, 32'd1);
        check("sat_status_bit4", {31'b0, rd_data[4]}, 32'd0);

        // Random traffic against the model.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 400; k++) begin
            v.en   = ($urandom_range(0, 3) != 0);
            v.rw   = $urandom_range(0, 1);
            v.mw   = $urandom_range(0, 1);
            v.hlt  = ($urandom_range(0, 39) == 0);
            v.ireq = $urandom_range(0, 1);
            v.ihit = ($urandom_range(0, 7) != 0) ? v.ireq : 1'b1;
            v.dreq = $urandom_range(0, 1);
            v.dhit = ($urandom_range(0, 7) != 0) ? v.dreq : 1'b1;
            v.clr  = ($urandom_range(0, 31) == 0);
            v.rd   = $urandom_range(0, 1);
            v.sel  = 3'($urandom_range(0, 7));
            step(v);
        end

        // Asynchronous reset in the middle of a read.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (3) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(rdv(0));
        check("pre_rst_valid", {31'b0, rd_valid}, 32'd1);
        check("pre_rst_data", {16'b0, rd_data}, 32'd3);
        apply(idle);
        #2 rst = 1'b0;
        m_reset();
        #1;
        check("async_rst_valid", {31'b0, rd_valid}, 32'd0);
        check("async_rst_data", {16'b0, rd_data}, 32'd0);
        check("async_rst_frozen", {31'b0, frozen}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        step(rdv(0));
        check("post_rst_sel0_valid", {31'b0, rd_valid}, 32'd1);
        check("post_rst_sel0", {16'b0, rd_data}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_event_counter.md
# perf_event_counter

Hardware performance monitor that sits directly downstream of the processor's writeback and memory stages. Each cycle it consumes the same retirement and cache-event strobes the pipeline bench samples (register write, memory write, halt, I/D-cache request and hit). It keeps saturating event counters, freezes them on halt, and exposes them through a registered read port. Dump logic and the bench read final statistics from it, so software-side counting is no longer needed.

## Interface
Parameters:
- CNT_W, 32, counter width in bits; legal range 16..32.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset (0 = in reset).
- en  in  1  count enable; when 0, no counter changes (reads still served).
- reg_write  in  1  writeback stage writing register file this cycle.
- mem_write  in  1  memory stage committing a store this cycle.
- halt  in  1  halt instruction in memory/writeback this cycle.
- icache_req  in  1  valid instruction-cache request.
- icache_hit  in  1  instruction-cache hit.
- dcache_req  in  1  valid data-cache read/write request.
- dcache_hit  in  1  data-cache hit.
- clr  in  1  synchronous clear pulse.
- rd_en  in  1  read request.
- rd_sel  in  3  counter select.
- rd_data  out  CNT_W  selected value, registered.
- rd_valid  out  1  rd_data valid.
- frozen  out  1  halt has been counted; counters stopped.

## Operation
- Counter map (rd_sel): 0 cycles, 1 retired insts, 2 icache_req, 3 icache_hit, 4 dcache_req, 5 dcache_hit, 6 halt_cycle (snapshot), 7 status.
- Active cycle = en & ~frozen. Counter updates happen only on active cycles.
- On an active cycle:
  - cycles += 1.
  - insts += 1 if (halt | reg_write | mem_write); at most +1 per cycle.
  - Each cache counter += 1 when its strobe is 1.
- Saturation: a counter at all-ones holds its value and sets its sticky overflow bit.
- Halt on an active cycle:
  - That cycle is counted normally.
  - halt_cycle <= cycles value before increment (0-based cycle index of the halt).
  - frozen <= 1.
- Further halts while frozen are ignored.
- Protocol errors (sticky):
  - ihit_err set on an active cycle with icache_hit & ~icache_req.
  - dhit_err set likewise for the D-cache.
  - The hit is still counted.
- Status word, zero-extended to CNT_W:
  - bit0 frozen.
  - bit1 ihit_err.
  - bit2 dhit_err.
  - bits[8:3] overflow flags for counters 0..5.
- clr: all counters, halt_cycle, flags and frozen go to 0. Applies regardless of en.
- Priority:
  - clr beats every event and halt in the same cycle; the result is all zero and not frozen.
  - A read in the same cycle as clr returns the pre-clear value.

## Timing
- Reset (rst=0, asynchronous): every counter, halt_cycle, every flag, frozen, rd_data and rd_valid = 0.
- Read latency 1:
  - rd_en=1 at edge N gives rd_valid=1 and rd_data = value before edge N's update, during cycle N+1.
  - rd_valid=0 on cycles without a prior rd_en.
  - rd_data holds its last value when rd_valid=0.
- Back-to-back reads are allowed every cycle; there is no stall.
- frozen rises the cycle after the halt edge, so it is visible together with the frozen counter values.
- Reset asserted mid-operation or mid-read: outputs go to 0 immediately, and a pending rd_valid is dropped.

## Test plan
- Reset, then en=1 for 10 cycles with reg_write high on 4 of them and mem_write on 2 (one overlapping a reg_write) -> read sel1 = 5, sel0 = 10.
- 8 cycles of icache_req, with icache_hit on 6 -> sel2 = 8, sel3 = 6. One extra hit without req -> sel3 = 7 and status bit1 = 1.
- Halt on cycle index 20 with reg_write the same cycle -> frozen=1 next cycle, sel6 = 20, sel1 includes the halt; 5 more event cycles leave all counts unchanged.
- clr asserted together with halt and rd_en(sel0=12) -> rd_data = 12, then all reads 0 and frozen=0.
- CNT_W=16: preload by running 65535 active cycles, then 3 more -> sel0 = 0xFFFF, status bit3 = 1.
- rst dropped to 0 mid-read -> rd_valid and rd_data go to 0 asynchronously; after release, sel0 reads 0 with en=0.
